// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of one Avalon-MM port between fetch and data masters,
// one transaction in flight, with read-data timeout recovery.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_read,
    output logic              if_wait,
    output logic [31:0]       if_rdata,
    output logic              if_rvalid,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [31:0]       dm_wdata,
    input  logic [3:0]        dm_byteen,
    output logic              dm_wait,
    output logic [31:0]       dm_rdata,
    output logic              dm_rvalid,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_read,
    output logic              m_write,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_byteen,
    input  logic              m_waitrequest,
    input  logic [31:0]       m_readdata,
    input  logic              m_readdatavalid,
    output logic              timeout_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA} state_t;
    localparam logic [15:0] LAST_CNT = 16'(TIMEOUT - 1);

    state_t            state;
    logic              run;
    logic              own_dm;
    logic              last_dm;
    logic [15:0]       cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        byteen_q;
    logic              issue;
    logic              dm_req;
    logic              own_req;
    logic              grant_dm;

    assign issue    = state == ISSUE;
    assign dm_req   = dm_read | dm_write;
    assign own_req  = own_dm ? dm_req : if_read;
    // on a tie the master not granted last wins
    assign grant_dm = dm_req && (!if_read || !last_dm);

    assign m_read   = issue && (own_dm ? dm_read && !dm_write : if_read);
    assign m_write  = issue && own_dm && dm_write;
    assign m_addr   = issue ? (own_dm ? dm_addr : if_addr) : addr_q;
    assign m_wdata  = issue && own_dm ? dm_wdata : wdata_q;
    assign m_byteen = issue ? (own_dm ? dm_byteen : 4'hF) : byteen_q;
    assign if_wait  = !(issue && !own_dm && !m_waitrequest);
    assign dm_wait  = !(issue && own_dm && !m_waitrequest);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            run         <= 1'b0;
            own_dm      <= 1'b0;
            last_dm     <= 1'b0;
            cnt         <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            byteen_q    <= '0;
            if_rdata    <= '0;
            dm_rdata    <= '0;
            if_rvalid   <= 1'b0;
            dm_rvalid   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            // single-flop release stage: the FSM first moves on the 2nd edge after reset_n rises
            run         <= 1'b1;
            if_rvalid   <= 1'b0;
            dm_rvalid   <= 1'b0;
            timeout_err <= 1'b0;
            if (issue) begin
                addr_q   <= m_addr;
                wdata_q  <= m_wdata;
                byteen_q <= m_byteen;
            end
            case (state)
                IDLE: if (run && (if_read || dm_req)) begin
                    own_dm  <= grant_dm;
                    last_dm <= grant_dm;
                    state   <= ISSUE;
                end
                ISSUE: if (!own_req) begin
                    state <= IDLE;
                end else if (!m_waitrequest) begin
                    state <= m_write ? IDLE : WAIT_DATA;
                    cnt   <= '0;
                end
                WAIT_DATA: if (m_readdatavalid || cnt == LAST_CNT) begin
                    if_rvalid   <= !own_dm;
                    dm_rvalid   <= own_dm;
                    timeout_err <= !m_readdatavalid;
                    if (own_dm) dm_rdata <= m_readdatavalid ? m_readdata : 32'hDEADBEEF;
                    else if_rdata <= m_readdatavalid ? m_readdata : 32'hDEADBEEF;
                    state <= IDLE;
                end else begin
                    cnt <= cnt + 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenario bench for mem_port_arbiter (TIMEOUT=8).
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, m_readdata = '0;
    logic        if_read = 1'b0, dm_read = 1'b0, dm_write = 1'b0;
    logic [3:0]  dm_byteen = '0;
    logic        m_waitrequest = 1'b0, m_readdatavalid = 1'b0;
    logic        if_wait, if_rvalid, dm_wait, dm_rvalid, m_read, m_write, timeout_err;
    logic [31:0] if_rdata, dm_rdata, m_addr, m_wdata;
    logic [3:0]  m_byteen;
    int          total = 0, bad = 0, wr_acc = 0, n;

    mem_port_arbiter #(.ADDR_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_addr(if_addr), .if_read(if_read), .if_wait(if_wait), .if_rdata(if_rdata), .if_rvalid(if_rvalid),
        .dm_addr(dm_addr), .dm_read(dm_read), .dm_write(dm_write), .dm_wdata(dm_wdata), .dm_byteen(dm_byteen),
        .dm_wait(dm_wait), .dm_rdata(dm_rdata), .dm_rvalid(dm_rvalid),
        .m_addr(m_addr), .m_read(m_read), .m_write(m_write), .m_wdata(m_wdata), .m_byteen(m_byteen),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (m_write && !m_waitrequest) wr_acc <= wr_acc + 1;

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({if_wait, dm_wait, if_rvalid, dm_rvalid, m_read, m_write, timeout_err} !== 7'b1100000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 1100000", {if_wait, dm_wait, if_rvalid, dm_rvalid, m_read, m_write, timeout_err});
        end
        total++;
        if ({if_rdata, dm_rdata, m_addr, m_wdata, m_byteen} !== 132'd0) begin
            bad++;
            $display("FAIL reset_data: got %h want 0", {if_rdata, dm_rdata, m_addr, m_wdata, m_byteen});
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({if_wait, dm_wait, m_read, m_write} !== 4'b1100) begin
            bad++;
            $display("FAIL idle_after_release: got %b want 1100", {if_wait, dm_wait, m_read, m_write});
        end
    endtask

    task automatic test_if_read();
        @(negedge clk);
        if_read = 1'b1; if_addr = 32'h100; m_waitrequest = 1'b0;
        #1;
        total++;
        if (m_read !== 1'b0) begin bad++; $display("FAIL if_read_c0: m_read=%b want 0", m_read); end
        @(negedge clk); #1;
        total++;
        if ({m_read, m_write, m_addr, m_byteen, if_wait, dm_wait} !== {1'b1, 1'b0, 32'h100, 4'hF, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL if_read_c1: rd=%b wr=%b addr=%h be=%h ifw=%b dmw=%b want 1 0 100 f 0 1", m_read, m_write, m_addr, m_byteen, if_wait, dm_wait);
        end
        @(negedge clk);
        if_read = 1'b0; m_readdatavalid = 1'b1; m_readdata = 32'h13;
        #1;
        total++;
        if ({m_read, if_rvalid, dm_wait} !== 3'b001) begin
            bad++;
            $display("FAIL if_read_c2: rd=%b rv=%b dmw=%b want 0 0 1", m_read, if_rvalid, dm_wait);
        end
        @(negedge clk);
        m_readdatavalid = 1'b0;
        #1;
        total++;
        if ({if_rvalid, if_rdata, dm_rvalid, dm_wait, timeout_err} !== {1'b1, 32'h13, 1'b0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL if_read_c3: rv=%b rdata=%h dmrv=%b dmw=%b to=%b want 1 13 0 1 0", if_rvalid, if_rdata, dm_rvalid, dm_wait, timeout_err);
        end
        @(negedge clk); #1;
        total++;
        if ({if_rvalid, m_addr} !== {1'b0, 32'h100}) begin
            bad++;
            $display("FAIL if_read_c4: rv=%b addr=%h want 0 100", if_rvalid, m_addr);
        end
    endtask

    task automatic test_tie();
        logic [2:0] order;
        order = 3'b101;
        @(negedge clk);
        if_read = 1'b1; if_addr = 32'h1A0; dm_read = 1'b1; dm_addr = 32'hD00;
        for (int r = 0; r < 3; r++) begin
            n = 0;
            do begin @(negedge clk); #1; n++; end while (!m_read && n < 10);
            total++;
            if ({m_read, dm_wait, if_wait, m_addr} !== {1'b1, !order[r], order[r], order[r] ? 32'hD00 : 32'h1A0}) begin
                bad++;
                $display("FAIL tie_grant%0d: rd=%b dmw=%b ifw=%b addr=%h want dm=%b", r, m_read, dm_wait, if_wait, m_addr, order[r]);
            end
            @(negedge clk);
            m_readdatavalid = 1'b1; m_readdata = 32'(r + 5);
            @(negedge clk);
            m_readdatavalid = 1'b0;
            #1;
            total++;
            if ({if_rvalid, dm_rvalid, order[r] ? dm_rdata : if_rdata} !== {!order[r], order[r], 32'(r + 5)}) begin
                bad++;
                $display("FAIL tie_resp%0d: ifrv=%b dmrv=%b ifd=%h dmd=%h want dm=%b data=%0d", r, if_rvalid, dm_rvalid, if_rdata, dm_rdata, order[r], r + 5);
            end
        end
        if_read = 1'b0; dm_read = 1'b0;
    endtask

    task automatic test_dm_write();
        int w0;
        @(negedge clk);
        w0 = wr_acc;
        dm_write = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'hCAFEBABE; dm_byteen = 4'b0011; m_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            total++;
            if ({m_write, m_read, m_addr, m_wdata, m_byteen, dm_wait, if_wait} !== {1'b1, 1'b0, 32'h2000, 32'hCAFEBABE, 4'b0011, 1'b1, 1'b1}) begin
                bad++;
                $display("FAIL wr_stall%0d: wr=%b rd=%b addr=%h d=%h be=%b dmw=%b ifw=%b", i, m_write, m_read, m_addr, m_wdata, m_byteen, dm_wait, if_wait);
            end
        end
        @(negedge clk);
        m_waitrequest = 1'b0;
        #1;
        total++;
        if ({m_write, dm_wait} !== 2'b10) begin bad++; $display("FAIL wr_accept: wr=%b dmw=%b want 1 0", m_write, dm_wait); end
        @(negedge clk);
        dm_write = 1'b0;
        #1;
        total++;
        if ({m_write, m_addr, m_byteen, dm_rvalid} !== {1'b0, 32'h2000, 4'b0011, 1'b0}) begin
            bad++;
            $display("FAIL wr_after: wr=%b addr=%h be=%b rv=%b want 0 2000 0011 0", m_write, m_addr, m_byteen, dm_rvalid);
        end
        @(negedge clk); #1;
        total++;
        if (dm_rvalid !== 1'b0 || wr_acc - w0 != 1) begin
            bad++;
            $display("FAIL wr_count: rv=%b writes=%0d want 0 1", dm_rvalid, wr_acc - w0);
        end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        dm_read = 1'b1; dm_addr = 32'h40; m_waitrequest = 1'b0;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!m_read && n < 10);
        total++;
        if (m_read !== 1'b1) begin bad++; $display("FAIL to_issue: m_read=%b want 1", m_read); end
        n = 0;
        do begin @(negedge clk); dm_read = 1'b0; #1; n++; end while (!dm_rvalid && n < 30);
        total++;
        if ({n[7:0], dm_rvalid, dm_rdata, timeout_err, if_rvalid} !== {8'd9, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL to_resp: cycles=%0d rv=%b d=%h to=%b ifrv=%b want 9 1 deadbeef 1 0", n, dm_rvalid, dm_rdata, timeout_err, if_rvalid);
        end
        @(negedge clk);
        if_read = 1'b1; if_addr = 32'h300;
        #1;
        total++;
        if ({timeout_err, dm_rvalid} !== 2'b00) begin bad++; $display("FAIL to_pulse: to=%b rv=%b want 0 0", timeout_err, dm_rvalid); end
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!m_read && n < 10);
        total++;
        if ({m_read, m_addr} !== {1'b1, 32'h300}) begin bad++; $display("FAIL to_next: rd=%b addr=%h want 1 300", m_read, m_addr); end
        @(negedge clk);
        if_read = 1'b0; m_readdatavalid = 1'b1; m_readdata = 32'h55;
        @(negedge clk);
        m_readdatavalid = 1'b0;
        #1;
        total++;
        if ({if_rvalid, if_rdata, timeout_err} !== {1'b1, 32'h55, 1'b0}) begin
            bad++;
            $display("FAIL to_next_resp: rv=%b d=%h to=%b want 1 55 0", if_rvalid, if_rdata, timeout_err);
        end
    endtask

    task automatic test_both_rw();
        @(negedge clk);
        dm_read = 1'b1; dm_write = 1'b1; dm_addr = 32'h80; dm_wdata = 32'h12345678; dm_byteen = 4'hF;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!m_write && n < 10);
        total++;
        if ({m_write, m_read, m_wdata} !== {1'b1, 1'b0, 32'h12345678}) begin
            bad++;
            $display("FAIL rw_issue: wr=%b rd=%b d=%h want 1 0 12345678", m_write, m_read, m_wdata);
        end
        @(negedge clk);
        dm_read = 1'b0; dm_write = 1'b0;
        #1;
        repeat (2) begin @(negedge clk); #1; end
        total++;
        if ({m_write, m_read, dm_rvalid} !== 3'b000) begin
            bad++;
            $display("FAIL rw_done: wr=%b rd=%b rv=%b want 0 0 0", m_write, m_read, dm_rvalid);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        dm_read = 1'b1; dm_addr = 32'h500;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!m_read && n < 10);
        @(negedge clk);
        dm_read = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        total++;
        if ({if_wait, dm_wait, if_rvalid, dm_rvalid, m_read, m_write, timeout_err, m_addr, if_rdata} !== {7'b1100000, 64'd0}) begin
            bad++;
            $display("FAIL mid_reset: ctl=%b addr=%h ifd=%h", {if_wait, dm_wait, if_rvalid, dm_rvalid, m_read, m_write, timeout_err}, m_addr, if_rdata);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1; m_readdatavalid = 1'b1; m_readdata = 32'h77;
        @(negedge clk);
        m_readdatavalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            total++;
            if ({if_rvalid, dm_rvalid, m_read, timeout_err, dm_rdata, m_addr, m_byteen} !== 73'd0) begin
                bad++;
                $display("FAIL stray_rdv%0d: ifrv=%b dmrv=%b rd=%b to=%b dmd=%h addr=%h", i, if_rvalid, dm_rvalid, m_read, timeout_err, dm_rdata, m_addr);
            end
        end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1; if_read = 1'b1; if_addr = 32'h600;
        @(negedge clk); #1;
        total++;
        if (m_read !== 1'b0) begin bad++; $display("FAIL sync_edge1: m_read=%b want 0", m_read); end
        @(negedge clk); #1;
        total++;
        if ({m_read, m_addr} !== {1'b1, 32'h600}) begin bad++; $display("FAIL sync_edge2: rd=%b addr=%h want 1 600", m_read, m_addr); end
        @(negedge clk);
        if_read = 1'b0; m_readdatavalid = 1'b1; m_readdata = 32'h99;
        @(negedge clk);
        m_readdatavalid = 1'b0;
        #1;
        total++;
        if ({if_rvalid, if_rdata} !== {1'b1, 32'h99}) begin bad++; $display("FAIL sync_resp: rv=%b d=%h want 1 99", if_rvalid, if_rdata); end
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_tie();
        test_dm_write();
        test_timeout();
        test_both_rw();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 32, address width; TIMEOUT, 255, max cycles awaiting read data (1..65535).
REQ-002 Ports SHALL be as follows:
- clk  in  1  sole clock
- reset_n  in  1  reset, asynchronous, active-low
- if_addr  in  ADDR_W  fetch master address
- if_read  in  1  fetch read request
- if_wait  out  1  fetch waitrequest
- if_rdata  out  32  fetch read data
- if_rvalid  out  1  fetch read data valid
- dm_addr  in  ADDR_W  data master address
- dm_read  in  1  data read request
- dm_write  in  1  data write request
- dm_wdata  in  32  write data
- dm_byteen  in  4  byte enables
- dm_wait  out  1  data waitrequest
- dm_rdata  out  32  data read data
- dm_rvalid  out  1  data read data valid
- m_addr  out  ADDR_W  shared memory address
- m_read  out  1  shared memory read
- m_write  out  1  shared memory write
- m_wdata  out  32  shared write data
- m_byteen  out  4  shared byte enables
- m_waitrequest  in  1  memory stall
- m_readdata  in  32  memory read data
- m_readdatavalid  in  1  memory read data valid
- timeout_err  out  1  one-cycle pulse on read timeout

Function
REQ-003 The block SHALL share one Avalon-MM memory port between fetch (IF) and data (DM) masters, with at most one transaction outstanding.
REQ-004 FSM states SHALL be IDLE, ISSUE, WAIT_DATA.
REQ-005 IDLE: if any request is pending, latch owner and go to ISSUE next cycle; else stay.
REQ-006 Arbitration SHALL be round-robin: on a tie, grant the master not granted last; last_grant resets to IF, so the first tie goes to DM.
REQ-007 ISSUE: m_* SHALL reflect the owner's inputs combinationally; IF drives m_byteen=4'hF and m_write=0.
REQ-008 ISSUE: owner's wait SHALL be low only when m_waitrequest=0; non-owner wait SHALL be high in every state.
REQ-009 ISSUE, m_waitrequest=0: a write SHALL return to IDLE; a read SHALL go to WAIT_DATA.
REQ-010 DM with dm_read=1 and dm_write=1 together SHALL be handled as a write.
REQ-011 WAIT_DATA: m_read and m_write SHALL be 0; on m_readdatavalid, assert owner rvalid for exactly 1 cycle with rdata=m_readdata, then return to IDLE.
REQ-012 WAIT_DATA SHALL count cycles. When the count reaches TIMEOUT with no readdatavalid, assert owner rvalid with rdata=32'hDEADBEEF, pulse timeout_err for 1 cycle, and return to IDLE.
REQ-013 m_readdatavalid outside WAIT_DATA SHALL be ignored.
REQ-014 Latency: request sampled in IDLE at edge k -> m_read/m_write high in cycle k+1; minimum read round trip = 3 cycles with 1-cycle memory.
REQ-015 Masters SHALL hold request signals stable while wait=1; the arbiter does not re-sample the owner's address after grant.
REQ-016 A master whose request drops during ISSUE (protocol violation) SHALL cause return to IDLE without issuing.
REQ-017 Outside ISSUE: m_read=0 and m_write=0; m_addr, m_wdata and m_byteen hold their last values.

Reset
REQ-018 While reset_n=0:
- FSM in IDLE, last_grant=IF, timeout counter=0
- if_wait=dm_wait=1; if_rvalid=dm_rvalid=0; if_rdata=dm_rdata=0
- m_read=m_write=0; m_addr=0, m_wdata=0, m_byteen=0
- timeout_err=0
REQ-019 Assertion mid-transaction SHALL abort it immediately; no rvalid is generated afterward for the aborted read.
REQ-020 Deassertion SHALL be synchronised internally so that the first FSM transition occurs at the 2nd rising edge after release.

Verification
REQ-021 The bench SHALL cover the following scenarios:
- Single IF read, addr 0x100, memory 1-cycle latency returning 0x00000013 -> m_read for 1 cycle, if_rvalid=1 with if_rdata=0x13 in cycle 3, dm_wait=1 throughout.
- IF and DM both request from reset -> DM served first, then IF; repeated ties alternate DM, IF, DM.
- DM write addr 0x2000, data 0xCAFEBABE, byteen 4'b0011, m_waitrequest high 3 cycles -> dm_wait high 3 cycles, m_* stable, single write accepted, no dm_rvalid.
- DM read, memory never returns data, TIMEOUT=8 -> dm_rvalid=1, dm_rdata=0xDEADBEEF, timeout_err pulse, next request accepted.
- reset_n low during WAIT_DATA, stray m_readdatavalid after release -> no rvalid, all outputs at reset values.
- dm_read and dm_write both high -> write issued, m_read=0.
